// File: rtl/audio_track_sequencer_if.sv
// audio_track_sequencer_if: groups the sequencer's codec, ROM and game-side
// control signals. The master modport is the game/codec side; the slave
// modport is the sequencer itself.
// Optional feature macro: AUDIO_PAUSE_EN (adds the pause input).
interface audio_track_sequencer_if #(
   parameter int ADDR_W     = 17,
   parameter int DIV_W      = 16,
   parameter int NUM_TRACKS = 4,
   parameter int SEL_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
);
   logic                         INIT_FINISH;
   logic                         data_over;
   logic                         INIT;
   logic [NUM_TRACKS*ADDR_W-1:0] track_start;
   logic [NUM_TRACKS*ADDR_W-1:0] track_end;
   logic [SEL_W-1:0]             track_sel;
   logic [DIV_W-1:0]             sample_div;
   logic                         loop_en;
   logic                         play_req;
   logic                         stop_req;
   logic                         busy;
   logic                         done;
   logic                         overrun;
   logic [ADDR_W-1:0]            Add;
`ifdef AUDIO_PAUSE_EN
   logic                         pause;
`endif

   modport master (
`ifdef AUDIO_PAUSE_EN
      output pause,
`endif
      output INIT_FINISH, data_over, track_start, track_end, track_sel,
             sample_div, loop_en, play_req, stop_req,
      input  INIT, busy, done, overrun, Add
   );

   modport slave (
`ifdef AUDIO_PAUSE_EN
      input  pause,
`endif
      input  INIT_FINISH, data_over, track_start, track_end, track_sel,
             sample_div, loop_en, play_req, stop_req,
      output INIT, busy, done, overrun, Add
   );
endinterface

// File: rtl/audio_track_sequencer.sv
// audio_track_sequencer: waits for codec initialisation, then steps the audio
// ROM address through one of NUM_TRACKS sample regions at a programmable
// sample rate, in one-shot or loop mode, under play/stop requests.
// Optional feature macro: AUDIO_PAUSE_EN (pause input freezes playback).
module audio_track_sequencer #(
   parameter int ADDR_W     = 17,
   parameter int DIV_W      = 16,
   parameter int NUM_TRACKS = 4,
   parameter int SEL_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
   input logic                    Clk,
   input logic                    Reset,
   audio_track_sequencer_if.slave bus
);
   typedef enum logic [1:0] {S_WAIT_INIT, S_READY, S_PLAY} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] add, add_next;
   logic [DIV_W-1:0]  div_cnt, div_next;
   logic              pending, pending_next;
   logic              overrun_r, overrun_next;
   logic              done_r, done_next;
   logic              init_r;

   // Parameters of the playback in progress, captured at play time
   logic [ADDR_W-1:0] start_r, end_r;
   logic [DIV_W-1:0]  div_r;
   logic              loop_r;

   logic [SEL_W-1:0]  sel;
   logic [31:0]       sel_ext;
   logic [ADDR_W-1:0] start_sel, end_sel;
   logic [DIV_W-1:0]  div_sel;
   logic              sel_ok, play_ok, wrap, paused, load;

   assign sel     = bus.track_sel;
   // A divider of zero would mean no clocks per sample; it runs as one
   assign div_sel = (bus.sample_div == '0) ? DIV_W'(1) : bus.sample_div;
   assign play_ok = bus.play_req & ~bus.stop_req & sel_ok;
   assign wrap    = (div_cnt == div_r);

`ifdef AUDIO_PAUSE_EN
   assign paused = bus.pause;
`else
   assign paused = 1'b0;
`endif

   // Pick the selected track's address range; out-of-range selects stay invalid
   always_comb begin
      sel_ext   = 32'(sel);
      start_sel = '0;
      end_sel   = '0;
      sel_ok    = 1'b0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         if (sel_ext == 32'(i)) begin
            start_sel = bus.track_start[i*ADDR_W +: ADDR_W];
            end_sel   = bus.track_end[i*ADDR_W +: ADDR_W];
            sel_ok    = 1'b1;
         end
      end
   end

   // Next-state, address, divider and status decisions
   always_comb begin
      state_next   = state;
      add_next     = add;
      div_next     = div_cnt;
      pending_next = pending;
      overrun_next = overrun_r;
      done_next    = 1'b0;
      load         = 1'b0;
      case (state)
         S_WAIT_INIT: begin
            add_next = '0;
            if (bus.INIT_FINISH) state_next = S_READY;
         end
         S_READY: begin
            if (play_ok) begin
               load         = 1'b1;
               state_next   = S_PLAY;
               add_next     = start_sel;
               div_next     = '0;
               pending_next = 1'b0;
            end
         end
         S_PLAY: begin
            if (bus.stop_req) begin
               // Stop wins over both a restart and a same-cycle advance
               state_next = S_READY;
               done_next  = 1'b1;
            end else if (play_ok) begin
               load         = 1'b1;
               add_next     = start_sel;
               div_next     = '0;
               pending_next = 1'b0;
            end else if (!paused) begin
               div_next     = wrap ? '0 : div_cnt + DIV_W'(1);
               // A new tick keeps pending set even if the old one is consumed
               pending_next = wrap | (pending & ~bus.data_over);
               if (wrap && pending) overrun_next = 1'b1;
               if (pending && bus.data_over) begin
                  // start > end lands here on the first advance as well
                  if (add < end_r) begin
                     add_next = add + ADDR_W'(1);
                  end else if (loop_r) begin
                     add_next = start_r;
                  end else begin
                     add_next   = end_r;
                     state_next = S_READY;
                     done_next  = 1'b1;
                  end
               end
            end
         end
         default: state_next = S_WAIT_INIT;
      endcase
   end

   // FSM state register
   always_ff @(posedge Clk) begin
      if (Reset) state <= S_WAIT_INIT;
      else       state <= state_next;
   end

   // Address, divider and status registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         add       <= '0;
         div_cnt   <= '0;
         pending   <= 1'b0;
         overrun_r <= 1'b0;
         done_r    <= 1'b0;
         init_r    <= 1'b0;
      end else begin
         add       <= add_next;
         div_cnt   <= div_next;
         pending   <= pending_next;
         overrun_r <= overrun_next;
         done_r    <= done_next;
         init_r    <= 1'b1;
      end
   end

   // Capture the track parameters at each accepted play request
   always_ff @(posedge Clk) begin
      if (load) begin
         start_r <= start_sel;
         end_r   <= end_sel;
         div_r   <= div_sel;
         loop_r  <= bus.loop_en;
      end
   end

   assign bus.INIT    = init_r;
   assign bus.busy    = (state == S_PLAY);
   assign bus.done    = done_r;
   assign bus.overrun = overrun_r;
   assign bus.Add     = add;
endmodule
